ram8_fill_ctrl: RTL

Front-end controller that drives the `in`/`address`/`load` port of an 8-word × 16-bit RAM8 and returns its `out` data to the host. RAM8 words have no reset, so after every reset this block clears all eight words to 0x0000. It then gives the host single-word reads and writes, and runs a block-fill operation on command. It sits directly upstream of RAM8: its `ram_*` outputs connect one-to-one to RAM8's inputs.

---
 rtl/ram8_fill_ctrl_if.sv | 28 ++
 rtl/ram8_fill_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ram8_fill_ctrl_if.sv
// Host and RAM8-side signal bundle for ram8_fill_ctrl.
// The slave modport is the controller; the master modport is the host/RAM side.
interface ram8_fill_ctrl_if;
    logic [15:0] host_in;
    logic [2:0]  host_address;
    logic        host_load;
    logic        fill_start;
    logic [15:0] fill_value;
    logic        fill_incr;
    logic [15:0] ram_out;
    logic [15:0] ram_in;
    logic [2:0]  ram_address;
    logic        ram_load;
    logic [15:0] host_out;
    logic        busy;
    logic        done;
    logic        host_drop;

    modport slave (
        input  host_in, host_address, host_load, fill_start, fill_value, fill_incr, ram_out,
        output ram_in, ram_address, ram_load, host_out, busy, done, host_drop
    );

    modport master (
        output host_in, host_address, host_load, fill_start, fill_value, fill_incr, ram_out,
        input  ram_in, ram_address, ram_load, host_out, busy, done, host_drop
    );
endinterface

// File: rtl/ram8_fill_ctrl.sv
// Front-end for an 8 x 16 RAM8: zero-clears the RAM after reset, then serves
// host single-word reads/writes and a constant or incrementing block fill.
module ram8_fill_ctrl (
    input  logic             clk,
    input  logic             reset,
    ram8_fill_ctrl_if.slave  bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_base, w_base_nxt;
    logic                r_incr, w_incr_nxt;
    logic [DATA_W-1:0]   r_ram_in, w_ram_in_nxt;
    logic [ADDR_W-1:0]   r_ram_address, w_ram_address_nxt;
    logic                r_ram_load, w_ram_load_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_host_drop, w_host_drop_nxt;
    logic                w_last;

    assign w_last = (r_cnt == ADDR_W'(7));

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_CLEAR;
            r_cnt         <= '0;
            r_base        <= '0;
            r_incr        <= 1'b0;
            r_ram_in      <= '0;
            r_ram_address <= '0;
            r_ram_load    <= 1'b0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_host_drop   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_base        <= w_base_nxt;
            r_incr        <= w_incr_nxt;
            r_ram_in      <= w_ram_in_nxt;
            r_ram_address <= w_ram_address_nxt;
            r_ram_load    <= w_ram_load_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_host_drop   <= w_host_drop_nxt;
        end
    end

    // Next-state and RAM port decode
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_base_nxt        = r_base;
        w_incr_nxt        = r_incr;
        w_ram_in_nxt      = r_ram_in;
        w_ram_address_nxt = r_ram_address;
        w_ram_load_nxt    = 1'b0;
        w_done_nxt        = 1'b0;
        w_host_drop_nxt   = r_host_drop;

        case (r_state)
            ST_CLEAR: begin
                w_ram_address_nxt = r_cnt;
                w_ram_in_nxt      = '0;
                w_ram_load_nxt    = 1'b1;
                w_cnt_nxt         = r_cnt + ADDR_W'(1);
                if (w_last) w_state_nxt = ST_IDLE;
                if (bus.host_load) w_host_drop_nxt = 1'b1;
            end
            ST_IDLE: begin
                if (bus.fill_start) begin
                    // Word 0 goes out on the accepting edge; a coincident write loses.
                    w_base_nxt        = bus.fill_value;
                    w_incr_nxt        = bus.fill_incr;
                    w_state_nxt       = ST_FILL;
                    w_ram_address_nxt = '0;
                    w_ram_in_nxt      = bus.fill_value;
                    w_ram_load_nxt    = 1'b1;
                    w_cnt_nxt         = ADDR_W'(1);
                    if (bus.host_load) w_host_drop_nxt = 1'b1;
                end else begin
                    w_ram_address_nxt = bus.host_address;
                    w_ram_in_nxt      = bus.host_in;
                    w_ram_load_nxt    = bus.host_load;
                end
            end
            ST_FILL: begin
                w_ram_address_nxt = r_cnt;
                w_ram_in_nxt      = r_base + (r_incr ? DATA_W'(r_cnt) : '0);
                w_ram_load_nxt    = 1'b1;
                w_cnt_nxt         = r_cnt + ADDR_W'(1);
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
                if (bus.host_load) w_host_drop_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign bus.ram_in      = r_ram_in;
    assign bus.ram_address = r_ram_address;
    assign bus.ram_load    = r_ram_load;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.host_drop   = r_host_drop;
    // Read data is a straight wire from RAM8; it tracks ram_address, not host_address.
    assign bus.host_out    = bus.ram_out;
endmodule
